// File: rtl/itcm_arbiter_if.sv
// Bus bundle between the fetch/load-store ports, the arbiter and the ITCM SRAM.
// slave modport: arbiter side. master modport: core + SRAM side.
interface itcm_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    localparam int unsigned WORD_W = ADDR_WIDTH - 2;

    // Fetch port
    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              if_err_o;

    // Load-store port
    logic              ls_req_i;
    logic              ls_we_i;
    logic [31:0]       ls_addr_i;
    logic [31:0]       ls_wdata_i;
    logic [3:0]        ls_be_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [31:0]       ls_rdata_o;
    logic              ls_err_o;

    // Single-port SRAM
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [WORD_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/itcm_arbiter.sv
// ITCM arbiter: shares one single-port SRAM between instruction fetch and
// load-store. Combinational grants, fixed 1-cycle response, load-store wins by
// default. Optional fetch aging enabled with macro ITCM_ARB_AGING_EN.
module itcm_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic           clk,
    input  logic           rst,
    itcm_arbiter_if.slave  bus
);
    localparam int unsigned WORD_W = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        RSP_NONE   = 3'd0,
        RSP_IF     = 3'd1,
        RSP_LS     = 3'd2,
        RSP_IF_ERR = 3'd3,
        RSP_LS_ERR = 3'd4
    } rsp_state_e;

    rsp_state_e state_q, state_d;
    logic       ls_wr_q, ls_wr_d;
    logic       if_gnt, ls_gnt;
    logic       if_ok, ls_ok;
    logic       force_if;

    // Access is legal only inside the ITCM window and word aligned
    function automatic logic addr_ok(input logic [31:0] a);
        return ((a >> ADDR_WIDTH) == 32'd0) && (a[1:0] == 2'b00);
    endfunction

    assign if_ok = addr_ok(bus.if_addr_i);
    assign ls_ok = addr_ok(bus.ls_addr_i);

`ifdef ITCM_ARB_AGING_EN
    logic [CNT_W-1:0] wait_q;

    // Count consecutive denied fetch cycles, saturating at MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (!bus.if_req_i || if_gnt) begin
            wait_q <= '0;
        end else if (wait_q != CNT_W'(MAX_WAIT)) begin
            wait_q <= wait_q + CNT_W'(1);
        end
    end

    assign force_if = (wait_q == CNT_W'(MAX_WAIT)) && bus.if_req_i;
`else
    assign force_if = 1'b0;
`endif

    // Arbitration and SRAM request for the winning port
    always_comb begin
        ls_gnt          = 1'b0;
        if_gnt          = 1'b0;
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 4'b0000;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = 32'd0;
        if (!rst) begin
            ls_gnt = bus.ls_req_i && !force_if;
            if_gnt = bus.if_req_i && !ls_gnt;
            if (ls_gnt && ls_ok) begin
                bus.mem_en_o   = 1'b1;
                bus.mem_addr_o = WORD_W'(bus.ls_addr_i[ADDR_WIDTH-1:2]);
                if (bus.ls_we_i) begin
                    bus.mem_we_o    = bus.ls_be_i;
                    bus.mem_wdata_o = bus.ls_wdata_i;
                end
            end else if (if_gnt && if_ok) begin
                bus.mem_en_o   = 1'b1;
                bus.mem_addr_o = WORD_W'(bus.if_addr_i[ADDR_WIDTH-1:2]);
            end
        end
    end

    assign bus.if_gnt_o = if_gnt;
    assign bus.ls_gnt_o = ls_gnt;

    // Response state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RSP_NONE;
            ls_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ls_wr_q <= ls_wr_d;
        end
    end

    // Next response is decided by this cycle's grant
    always_comb begin
        state_d = RSP_NONE;
        ls_wr_d = 1'b0;
        if (ls_gnt) begin
            state_d = ls_ok ? RSP_LS : RSP_LS_ERR;
            ls_wr_d = bus.ls_we_i && ls_ok;
        end else if (if_gnt) begin
            state_d = if_ok ? RSP_IF : RSP_IF_ERR;
        end
    end

    // Response outputs; rdata stays zero unless a read response is valid
    always_comb begin
        bus.if_rvalid_o = 1'b0;
        bus.if_rdata_o  = 32'd0;
        bus.if_err_o    = 1'b0;
        bus.ls_rvalid_o = 1'b0;
        bus.ls_rdata_o  = 32'd0;
        bus.ls_err_o    = 1'b0;
        if (!rst) begin
            case (state_q)
                RSP_IF: begin
                    bus.if_rvalid_o = 1'b1;
                    bus.if_rdata_o  = bus.mem_rdata_i;
                end
                RSP_LS: begin
                    bus.ls_rvalid_o = 1'b1;
                    bus.ls_rdata_o  = ls_wr_q ? 32'd0 : bus.mem_rdata_i;
                end
                RSP_IF_ERR: begin
                    bus.if_rvalid_o = 1'b1;
                    bus.if_err_o    = 1'b1;
                end
                RSP_LS_ERR: begin
                    bus.ls_rvalid_o = 1'b1;
                    bus.ls_err_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/itcm_arbiter.md
ITCM_ARBITER -- requirements
Module: itcm_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, ITCM byte-address width; word index is ADDR_WIDTH-2 bits.
REQ-002 Parameter MAX_WAIT, default 4, consecutive fetch-denied cycles before forced fetch grant.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req_i  in  1  fetch read request, held stable until granted.
REQ-006 if_addr_i  in  32  fetch byte address.
REQ-007 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid_o / if_rdata_o / if_err_o  out  1/32/1  fetch response.
REQ-009 ls_req_i, ls_we_i  in  1/1  load-store request and write select.
REQ-010 ls_addr_i, ls_wdata_i, ls_be_i  in  32/32/4  load-store address, write data, byte enables.
REQ-011 ls_gnt_o  out  1  load-store request accepted this cycle.
REQ-012 ls_rvalid_o / ls_rdata_o / ls_err_o  out  1/32/1  load-store response.
REQ-013 mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o  out  1/4/ADDR_WIDTH-2/32  single-port SRAM request.
REQ-014 mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_en_o with mem_we_o==0.

Function
REQ-015 Grants are combinational from same-cycle requests; at most one of if_gnt_o/ls_gnt_o high per cycle.
REQ-016 Default priority: load-store over fetch.
REQ-017 Granted in-range access drives mem_en_o=1 in the same cycle; mem_addr_o=addr[ADDR_WIDTH-1:2]; mem_we_o=ls_be_i when write, else 4'b0000.
REQ-018 Out-of-range (addr[31:ADDR_WIDTH]!=0) or misaligned (addr[1:0]!=0) request: granted, mem_en_o=0, error response next cycle.
REQ-019 Response FSM states RSP_NONE, RSP_IF, RSP_LS, RSP_IF_ERR, RSP_LS_ERR; next state set by the granted request each cycle, RSP_NONE if no grant.
REQ-020 In RSP_IF: if_rvalid_o=1, if_rdata_o=mem_rdata_i; RSP_LS (read only): ls_rvalid_o=1, ls_rdata_o=mem_rdata_i.
REQ-021 Granted in-range write: ls_rvalid_o=1 next cycle with ls_err_o=0, ls_rdata_o=0.
REQ-022 Error states: rvalid=1, err=1, rdata=0 on the owning port; err outputs 0 otherwise.
REQ-023 Read latency exactly 1 cycle; back-to-back grants every cycle allowed (fully pipelined, no bubbles).
REQ-024 Both requests simultaneous: one granted, other gnt=0 and must retry; no request lost or duplicated.
REQ-025 rdata outputs are 0 whenever corresponding rvalid is 0.

Reset
REQ-026 While rst=1: FSM=RSP_NONE, wait counter=0, all gnt/rvalid/err/mem_* outputs 0, rdata 0.
REQ-027 rst asserted mid-transaction discards any pending response; no rvalid in the cycle after rst deasserts.
REQ-028 First grant possible in the first cycle with rst=0.

Configuration
REQ-029 Macro ITCM_ARB_AGING_EN: when defined, a wait counter increments each cycle if_req_i=1 and if_gnt_o=0, clears on fetch grant or if_req_i=0, saturates at MAX_WAIT.
REQ-030 With ITCM_ARB_AGING_EN, counter==MAX_WAIT forces fetch priority that cycle; ls_gnt_o=0.
REQ-031 Without ITCM_ARB_AGING_EN: no counter, strict load-store priority, fetch may starve indefinitely.

Verification
REQ-032 Fetch 0x00000000, 0x4, 0x8 consecutive, no ls -> if_gnt_o=1 each cycle, if_rvalid_o 3 consecutive cycles with mem words 0,1,2.
REQ-033 Simultaneous if_req 0x10 and ls read 0x20 -> ls granted first (rdata word 8 next cycle), fetch granted following cycle (word 4).
REQ-034 ls write 0x40 data 0xDEADBEEF be 4'b0011 then ls read 0x40 -> mem_we_o=0011, read returns SRAM merge value, ls_err_o=0.
REQ-035 ls read 0x00010000 (ADDR_WIDTH=16) and fetch 0x2 -> each granted, mem_en_o=0, err=1, rdata=0 next cycle.
REQ-036 ITCM_ARB_AGING_EN, MAX_WAIT=4, ls_req_i and if_req_i held high -> fetch granted on 5th cycle; without macro fetch never granted in 20 cycles.
REQ-037 rst pulsed 1 cycle right after a read grant -> no rvalid on either port after reset; outputs all 0 during reset.
